// File: rtl/pong_ball_engine.sv
// Ball movement engine for Pong: moves, reflects, scores and re-serves the ball on a configurable grid.
// Optional paddle spin is enabled by defining PONG_BALL_SPIN_EN.
module pong_ball_engine #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_COORD_BITS    = 6,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_SPEED_START   = 1250000,
  parameter int c_SPEED_MIN     = 312500,
  parameter int c_SPEED_STEP    = 62500,
  parameter int c_SERVE_TICKS   = 20
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Game_Active,
  input  logic [c_COORD_BITS-1:0] i_Paddle_Y_P1,
  input  logic [c_COORD_BITS-1:0] i_Paddle_Y_P2,
  input  logic [c_COORD_BITS-1:0] i_Col_Count_Div,
  input  logic [c_COORD_BITS-1:0] i_Row_Count_Div,
  output logic [c_COORD_BITS-1:0] o_Ball_X,
  output logic [c_COORD_BITS-1:0] o_Ball_Y,
  output logic                    o_Draw_Ball,
  output logic                    o_Hit,
  output logic                    o_P1_Score,
  output logic                    o_P2_Score
);

  typedef enum logic [1:0] {IDLE, SERVE, RUN, MISS} t_State;

  localparam logic [c_COORD_BITS-1:0] c_CENTER_X  = c_COORD_BITS'(c_GAME_WIDTH / 2);
  localparam logic [c_COORD_BITS-1:0] c_CENTER_Y  = c_COORD_BITS'(c_GAME_HEIGHT / 2);
  localparam logic [c_COORD_BITS-1:0] c_ONE       = c_COORD_BITS'(1);
  localparam logic [c_COORD_BITS-1:0] c_P1_COL    = c_COORD_BITS'(1);
  localparam logic [c_COORD_BITS-1:0] c_P1_BOUNCE = c_COORD_BITS'(2);
  localparam logic [c_COORD_BITS-1:0] c_P2_COL    = c_COORD_BITS'(c_GAME_WIDTH - 2);
  localparam logic [c_COORD_BITS-1:0] c_P2_BOUNCE = c_COORD_BITS'(c_GAME_WIDTH - 3);
  localparam logic [c_COORD_BITS-1:0] c_X_LAST    = c_COORD_BITS'(c_GAME_WIDTH - 1);
  localparam logic [c_COORD_BITS-1:0] c_Y_LAST    = c_COORD_BITS'(c_GAME_HEIGHT - 1);
  localparam logic [c_COORD_BITS:0]   c_PAD_SPAN  = (c_COORD_BITS+1)'(c_PADDLE_HEIGHT - 1);
  localparam logic [31:0] c_PERIOD_START = 32'(c_SPEED_START);
  localparam logic [31:0] c_PERIOD_MIN   = 32'(c_SPEED_MIN);
  localparam logic [31:0] c_PERIOD_STEP  = 32'(c_SPEED_STEP);
  localparam logic [31:0] c_SERVE_LAST   = 32'(c_SERVE_TICKS - 1);

  // Speed-up with a floor; ordered so the subtraction can never underflow.
  function automatic logic [31:0] f_Faster(input logic [31:0] p_Period);
    if (p_Period >= c_PERIOD_MIN + c_PERIOD_STEP)
      return p_Period - c_PERIOD_STEP;
    else
      return c_PERIOD_MIN;
  endfunction

  t_State                  r_State;
  logic [c_COORD_BITS-1:0] r_Ball_X;
  logic [c_COORD_BITS-1:0] r_Ball_Y;
  logic                    r_Dir_X;
  logic                    r_Dir_Y;
  logic [31:0]             r_Period;
  logic [31:0]             r_Tick_Cnt;
  logic [31:0]             r_Serve_Cnt;
  logic                    r_Draw_Ball;
  logic                    r_Hit;
  logic                    r_P1_Score;
  logic                    r_P2_Score;

  logic                    w_Tick;
  logic [c_COORD_BITS:0]   w_Y_Ext;
  logic [c_COORD_BITS:0]   w_P1_Top;
  logic [c_COORD_BITS:0]   w_P1_Bot;
  logic [c_COORD_BITS:0]   w_P2_Top;
  logic [c_COORD_BITS:0]   w_P2_Bot;
  logic                    w_At_P1;
  logic                    w_At_P2;
  logic                    w_P1_Hit;
  logic                    w_P2_Hit;
  logic                    w_Dir_Y_Eff;
  logic                    w_Next_Dir_Y;
  logic [c_COORD_BITS-1:0] w_Next_Y;

  assign w_Tick   = (r_Tick_Cnt == r_Period - 32'd1);
  assign w_Y_Ext  = {1'b0, r_Ball_Y};
  assign w_P1_Top = {1'b0, i_Paddle_Y_P1};
  assign w_P1_Bot = w_P1_Top + c_PAD_SPAN;
  assign w_P2_Top = {1'b0, i_Paddle_Y_P2};
  assign w_P2_Bot = w_P2_Top + c_PAD_SPAN;

  assign w_At_P1  = !r_Dir_X && (r_Ball_X == c_P1_COL);
  assign w_At_P2  =  r_Dir_X && (r_Ball_X == c_P2_COL);
  assign w_P1_Hit = w_At_P1 && (w_Y_Ext >= w_P1_Top) && (w_Y_Ext <= w_P1_Bot);
  assign w_P2_Hit = w_At_P2 && (w_Y_Ext >= w_P2_Top) && (w_Y_Ext <= w_P2_Bot);

  // Vertical step: spin (if built in) picks the direction first, then a wall reflection wins.
  always_comb begin
    w_Dir_Y_Eff = r_Dir_Y;
`ifdef PONG_BALL_SPIN_EN
    if ((w_P1_Hit && (w_Y_Ext == w_P1_Top)) || (w_P2_Hit && (w_Y_Ext == w_P2_Top)))
      w_Dir_Y_Eff = 1'b0;
    else if ((w_P1_Hit && (w_Y_Ext == w_P1_Bot)) || (w_P2_Hit && (w_Y_Ext == w_P2_Bot)))
      w_Dir_Y_Eff = 1'b1;
`endif
    w_Next_Dir_Y = w_Dir_Y_Eff;
    w_Next_Y     = r_Ball_Y;
    if (w_Dir_Y_Eff && (r_Ball_Y == c_Y_LAST)) begin
      w_Next_Dir_Y = 1'b0;
      w_Next_Y     = r_Ball_Y - c_ONE;
    end else if (!w_Dir_Y_Eff && (r_Ball_Y == '0)) begin
      w_Next_Dir_Y = 1'b1;
      w_Next_Y     = r_Ball_Y + c_ONE;
    end else if (w_Dir_Y_Eff) begin
      w_Next_Y     = r_Ball_Y + c_ONE;
    end else begin
      w_Next_Y     = r_Ball_Y - c_ONE;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State     <= IDLE;
      r_Ball_X    <= c_CENTER_X;
      r_Ball_Y    <= c_CENTER_Y;
      r_Dir_X     <= 1'b1;
      r_Dir_Y     <= 1'b1;
      r_Period    <= c_PERIOD_START;
      r_Tick_Cnt  <= '0;
      r_Serve_Cnt <= '0;
      r_Draw_Ball <= 1'b0;
      r_Hit       <= 1'b0;
      r_P1_Score  <= 1'b0;
      r_P2_Score  <= 1'b0;
    end else begin
      r_Hit       <= 1'b0;
      r_P1_Score  <= 1'b0;
      r_P2_Score  <= 1'b0;
      r_Draw_Ball <= (i_Col_Count_Div == r_Ball_X) && (i_Row_Count_Div == r_Ball_Y);
      if (!i_Game_Active) begin
        r_State     <= IDLE;
        r_Ball_X    <= c_CENTER_X;
        r_Ball_Y    <= c_CENTER_Y;
        r_Period    <= c_PERIOD_START;
        r_Tick_Cnt  <= '0;
        r_Serve_Cnt <= '0;
      end else begin
        if (r_State != IDLE)
          r_Tick_Cnt <= w_Tick ? '0 : r_Tick_Cnt + 32'd1;
        case (r_State)
          IDLE: begin
            r_State     <= SERVE;
            r_Ball_X    <= c_CENTER_X;
            r_Ball_Y    <= c_CENTER_Y;
            r_Period    <= c_PERIOD_START;
            r_Tick_Cnt  <= '0;
            r_Serve_Cnt <= '0;
          end
          SERVE: begin
            if (w_Tick) begin
              if (r_Serve_Cnt == c_SERVE_LAST) begin
                r_State     <= RUN;
                r_Serve_Cnt <= '0;
              end else begin
                r_Serve_Cnt <= r_Serve_Cnt + 32'd1;
              end
            end
          end
          RUN: begin
            if (w_Tick) begin
              r_Ball_Y <= w_Next_Y;
              r_Dir_Y  <= w_Next_Dir_Y;
              if (w_At_P1) begin
                if (w_P1_Hit) begin
                  r_Dir_X  <= 1'b1;
                  r_Ball_X <= c_P1_BOUNCE;
                  r_Hit    <= 1'b1;
                  r_Period <= f_Faster(r_Period);
                end else begin
                  r_Ball_X   <= '0;
                  r_P2_Score <= 1'b1;
                  r_State    <= MISS;
                end
              end else if (w_At_P2) begin
                if (w_P2_Hit) begin
                  r_Dir_X  <= 1'b0;
                  r_Ball_X <= c_P2_BOUNCE;
                  r_Hit    <= 1'b1;
                  r_Period <= f_Faster(r_Period);
                end else begin
                  r_Ball_X   <= c_X_LAST;
                  r_P1_Score <= 1'b1;
                  r_State    <= MISS;
                end
              end else begin
                r_Ball_X <= r_Dir_X ? r_Ball_X + c_ONE : r_Ball_X - c_ONE;
              end
            end
          end
          MISS: begin
            // Next serve heads toward whoever just conceded.
            if (w_Tick) begin
              r_Dir_X     <= (r_Ball_X == c_X_LAST);
              r_Ball_X    <= c_CENTER_X;
              r_Ball_Y    <= c_CENTER_Y;
              r_Period    <= c_PERIOD_START;
              r_Serve_Cnt <= '0;
              r_State     <= SERVE;
            end
          end
          default: r_State <= IDLE;
        endcase
      end
    end
  end

  assign o_Ball_X    = r_Ball_X;
  assign o_Ball_Y    = r_Ball_Y;
  assign o_Draw_Ball = r_Draw_Ball;
  assign o_Hit       = r_Hit;
  assign o_P1_Score  = r_P1_Score;
  assign o_P2_Score  = r_P2_Score;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Testbench for pong_ball_engine: cycle-level reference model feeding a scoreboard queue,
// a draw-flag vector table, and directed sequences for walls, hits, misses and async reset.
module tb_pong_ball_engine;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int CB = 6;
  localparam int PH = 6;
  localparam int SS = 4;
  localparam int SM = 2;
  localparam int ST = 1;
  localparam int SV = 2;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          active = 1'b0;
  logic [CB-1:0] pad1   = '0;
  logic [CB-1:0] pad2   = '0;
  logic [CB-1:0] col    = '0;
  logic [CB-1:0] row    = '0;
  logic [CB-1:0] bx;
  logic [CB-1:0] by;
  logic          draw;
  logic          hit;
  logic          p1s;
  logic          p2s;

  pong_ball_engine #(
    .c_GAME_WIDTH(W), .c_GAME_HEIGHT(H), .c_COORD_BITS(CB), .c_PADDLE_HEIGHT(PH),
    .c_SPEED_START(SS), .c_SPEED_MIN(SM), .c_SPEED_STEP(ST), .c_SERVE_TICKS(SV)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Game_Active(active),
    .i_Paddle_Y_P1(pad1), .i_Paddle_Y_P2(pad2),
    .i_Col_Count_Div(col), .i_Row_Count_Div(row),
    .o_Ball_X(bx), .o_Ball_Y(by), .o_Draw_Ball(draw),
    .o_Hit(hit), .o_P1_Score(p1s), .o_P2_Score(p2s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic       hit;
    logic       p1;
    logic       p2;
    logic       draw;
  } exp_t;

  typedef struct {
    int col;
    int row;
    int exp;
  } vec_t;

  exp_t sb_q[$];
  exp_t ce;
  exp_t me;
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  bit   drive_auto = 0;
  bit   p1_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (written only by the model process)
  int mx = W/2, my = H/2, mdx = 1, mdy = 1, mper = SS, mcnt = 0, mserve = 0, mst = 0;
  int mdraw, nhit, np1, np2, edge_col, ptop, ny;
  bit tick, at_pad, got;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mx = W/2; my = H/2; mdx = 1; mdy = 1; mper = SS; mcnt = 0; mserve = 0; mst = 0;
      sb_q.delete();
      continue;
    end
    mdraw = (int'(col) == mx && int'(row) == my) ? 1 : 0;
    nhit = 0; np1 = 0; np2 = 0;
    if (!active) begin
      mst = 0; mx = W/2; my = H/2; mcnt = 0; mper = SS; mserve = 0;
    end else if (mst == 0) begin
      mst = 1;
    end else begin
      tick = (mcnt == mper - 1);
      mcnt = tick ? 0 : mcnt + 1;
      if (tick) begin
        if (mst == 1) begin
          mserve++;
          if (mserve == SV) begin mst = 2; mserve = 0; end
        end else if (mst == 3) begin
          mdx = (mx == 0) ? -1 : 1;
          mx = W/2; my = H/2; mper = SS; mst = 1; mserve = 0;
        end else begin
          edge_col = (mdx < 0) ? 1 : W-2;
          ptop     = (mdx < 0) ? int'(pad1) : int'(pad2);
          at_pad   = (mx == edge_col);
          got      = at_pad && (my >= ptop) && (my <= ptop + PH - 1);
`ifdef PONG_BALL_SPIN_EN
          if (got && my == ptop) mdy = -1;
          else if (got && my == ptop + PH - 1) mdy = 1;
`endif
          ny = my + mdy;
          if (ny > H-1) begin mdy = -1; ny = my - 1; end
          else if (ny < 0) begin mdy = 1; ny = my + 1; end
          my = ny;
          if (got) begin
            mdx = -mdx; nhit = 1;
            mper = (mper - ST < SM) ? SM : mper - ST;
          end else if (at_pad) begin
            if (mdx < 0) np2 = 1; else np1 = 1;
            mst = 3;
          end
          mx = mx + mdx;
        end
      end
    end
    me.x = 6'(mx); me.y = 6'(my);
    me.hit = 1'(nhit); me.p1 = 1'(np1); me.p2 = 1'(np2); me.draw = 1'(mdraw);
    sb_q.push_back(me);
  end

  // Scoreboard: every edge's expectation is compared at the following falling edge
  initial forever begin
    @(negedge clk);
    if (sb_q.size() > 0) begin
      ce = sb_q.pop_front();
      chk("cycle{x,y,hit,p1,p2,draw}", 32'({bx, by, hit, p1s, p2s, draw}), 32'(ce));
    end
  end

  // Paddle/draw-counter driver during play
  initial forever begin
    @(negedge clk);
    if (drive_auto) begin
      pad1 = p1_miss ? 6'd63 : by;
      pad2 = (by >= 6'd5) ? by - 6'd5 : 6'd0;
      col  = ($urandom_range(1) == 1) ? bx : 6'($urandom_range(39));
      row  = ($urandom_range(3) != 0) ? by : 6'($urandom_range(29));
    end
  end

  int  n;
  bit  ok;
  logic [CB-1:0] x0;
  int  hit_gap[3];

  initial begin
    tbl[0] = '{20, 15, 1}; tbl[1] = '{21, 15, 0}; tbl[2] = '{20, 15, 1}; tbl[3] = '{19, 15, 0};
    tbl[4] = '{20, 16, 0}; tbl[5] = '{20, 14, 0}; tbl[6] = '{20, 15, 1}; tbl[7] = '{0, 0, 0};
    hit_gap[0] = 3; hit_gap[1] = 2; hit_gap[2] = 2;

    #1 rst = 1'b1;
    #1;
    chk("rst_x", 32'(bx), 20); chk("rst_y", 32'(by), 15);
    chk("rst_hit", 32'(hit), 0); chk("rst_p1", 32'(p1s), 0);
    chk("rst_p2", 32'(p2s), 0); chk("rst_draw", 32'(draw), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_x", 32'(bx), 20); chk("idle_y", 32'(by), 15);

    drive_auto = 1; active = 1'b1;

    // Bottom wall bounce
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); if (by == 6'd29) ok = 1; end
    chk("wall_reach", 32'(ok), 1);
    for (int i = 0; i < 20 && by == 6'd29; i++) @(negedge clk);
    chk("wall_y", 32'(by), 28);
    chk("wall_pulses", 32'({hit, p1s, p2s}), 0);

    // Three paddle hits: move period 4 -> 3 -> 2 -> 2
    for (int k = 0; k < 3; k++) begin
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); if (hit) ok = 1; end
      chk("hit_seen", 32'(ok), 1);
      chk("hit_x", 32'(bx == 6'd2 || bx == 6'd37), 1);
      x0 = bx;
      @(negedge clk);
      chk("hit_pulse_len", 32'(hit), 0);
      n = 1;
      while (bx == x0 && n < 20) begin @(negedge clk); n++; end
      chk("hit_period", 32'(n), 32'(hit_gap[k]));
    end

    // P1 miss, freeze at the wall, re-serve toward P1
    p1_miss = 1;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin @(negedge clk); if (p2s) ok = 1; end
    chk("miss_seen", 32'(ok), 1);
    chk("miss_x", 32'(bx), 0);
    chk("miss_p1_quiet", 32'(p1s), 0);
    @(negedge clk);
    chk("miss_pulse_len", 32'(p2s), 0);
    n = 1;
    while (bx == 6'd0 && n < 50) begin @(negedge clk); n++; end
    chk("miss_hold", 32'(n), 2);
    chk("serve_x", 32'(bx), 20); chk("serve_y", 32'(by), 15);
    for (int i = 0; i < 100 && bx == 6'd20; i++) @(negedge clk);
    chk("launch_x", 32'(bx), 19);
    p1_miss = 0;

    // Async reset in the middle of play
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_x", 32'(bx), 20); chk("arst_y", 32'(by), 15);
    chk("arst_pulses", 32'({hit, p1s, p2s}), 0); chk("arst_draw", 32'(draw), 0);
    drive_auto = 0; active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_x", 32'(bx), 20); chk("post_rst_y", 32'(by), 15);

    // Draw flag table, ball parked at centre
    for (int i = 0; i < 8; i++) begin
      col = 6'(tbl[i].col); row = 6'(tbl[i].row);
      #1;
      if (i > 0) chk("draw_latency", 32'(draw), 32'(tbl[i-1].exp));
      @(negedge clk);
      chk("draw_tbl", 32'(draw), 32'(tbl[i].exp));
    end

    // Free play under the model
    drive_auto = 1; active = 1'b1;
    repeat (600) @(negedge clk);
    active = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised successor to the fixed-grid ball controller in the Pong demo. It moves a ball on a configurable game grid and reflects it off the top and bottom walls and off two paddles. It detects misses, pulses a score event and re-serves from the centre. Ball speed rises on every paddle hit. It sits between the paddle controllers and the score/draw logic in the Pong top level.

## Interface
Parameters:
- c_GAME_WIDTH, 40, grid columns; ≥ 6.
- c_GAME_HEIGHT, 30, grid rows; ≥ 4.
- c_COORD_BITS, 6, width of all coordinate ports.
- c_PADDLE_HEIGHT, 6, paddle length in rows.
- c_SPEED_START, 1250000, clocks per move after serve and after reset.
- c_SPEED_MIN, 312500, floor of the move period.
- c_SPEED_STEP, 62500, period reduction per paddle hit.
- c_SERVE_TICKS, 20, move periods the ball waits at centre before launch.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Game_Active  in  1  low forces IDLE.
- i_Paddle_Y_P1  in  c_COORD_BITS  top row of left paddle (column 0).
- i_Paddle_Y_P2  in  c_COORD_BITS  top row of right paddle (column c_GAME_WIDTH-1).
- i_Col_Count_Div  in  c_COORD_BITS  current draw column.
- i_Row_Count_Div  in  c_COORD_BITS  current draw row.
- o_Ball_X  out  c_COORD_BITS  ball column.
- o_Ball_Y  out  c_COORD_BITS  ball row.
- o_Draw_Ball  out  1  registered ball-pixel flag.
- o_Hit  out  1  one-cycle pulse on a paddle hit.
- o_P1_Score  out  1  one-cycle pulse when P2 misses.
- o_P2_Score  out  1  one-cycle pulse when P1 misses.

## Operation
- Reset values:
  - State IDLE.
  - o_Ball_X = c_GAME_WIDTH/2, o_Ball_Y = c_GAME_HEIGHT/2.
  - All pulses 0, o_Draw_Ball 0.
  - dir_x = right, dir_y = down.
  - Period = c_SPEED_START, tick counter 0.
- Tick: a 32-bit counter runs 0..period-1 in SERVE/RUN/MISS. The tick fires on the cycle the counter equals period-1; the counter returns to 0 on the same edge.
- IDLE:
  - Ball held at centre, counter 0, period = c_SPEED_START.
  - i_Game_Active high → SERVE.
- i_Game_Active low in any state → IDLE on the next edge; pulses are suppressed on that edge.
- SERVE:
  - Ball held at centre.
  - After c_SERVE_TICKS ticks → RUN; dir_x keeps its value.
- RUN, on each tick:
  - Y: down with Y == c_GAME_HEIGHT-1 → dir_y = up, Y-1. Up with Y == 0 → dir_y = down, Y+1. Otherwise step ±1.
  - X left with X == 1:
    - P1 hit when i_Paddle_Y_P1 ≤ Y ≤ i_Paddle_Y_P1 + c_PADDLE_HEIGHT-1, evaluated on the pre-move Y.
    - Hit → dir_x = right, X = 2, o_Hit pulse, period = max(period - c_SPEED_STEP, c_SPEED_MIN).
    - Miss → X = 0, o_P2_Score pulse, → MISS.
  - X right with X == c_GAME_WIDTH-2: mirror of the above against P2; a miss pulses o_P1_Score.
  - Otherwise step ±1.
  - Paddle range arithmetic is done in c_COORD_BITS+1 bits; no wrap.
- MISS:
  - Ball frozen at the wall column for one tick.
  - Then centre the ball, period = c_SPEED_START, dir_x set toward the player who conceded, → SERVE.
- Draw: o_Draw_Ball <= (i_Col_Count_Div == o_Ball_X && i_Row_Count_Div == o_Ball_Y), registered in every state.

## Timing
- Position and direction update on the tick edge; the new position is visible the cycle after the tick.
- o_Hit, o_P1_Score and o_P2_Score are high for exactly one clock, coincident with that position update.
- o_Draw_Ball has a 1-cycle latency from the counter inputs.
- Period change from a hit applies from the next move: the counter compares against the new period starting the cycle after the hit tick.
- Wall and paddle events on the same tick (corner): both axes reflect independently on that tick.
- i_Rst asserted mid-RUN: outputs take their reset values immediately, without waiting for a clock edge.

## Configuration
- PONG_BALL_SPIN_EN defined:
  - A hit on the paddle's top row forces dir_y = up.
  - A hit on its bottom row forces dir_y = down.
  - The forced direction applies to the Y step on the same tick. Middle rows leave dir_y unchanged.
  - A wall reflection on the same tick overrides spin.
- PONG_BALL_SPIN_EN undefined: a paddle hit never alters dir_y.

## Test plan
Test parameters: 40x30 grid, c_SPEED_START=4, c_SPEED_MIN=2, c_SPEED_STEP=1, c_SERVE_TICKS=2, c_PADDLE_HEIGHT=6.
- Reset: assert i_Rst mid-RUN → X=20, Y=15, pulses 0 immediately, before any clock edge; after release with active low, the ball stays at centre.
- Wall bounce: ball at Y=29 moving down → next tick Y=28, dir_y up, no pulse.
- P1 hit: ball X=1, Y=10, moving left, i_Paddle_Y_P1=8 → X=2, o_Hit for one cycle, period 4→3. Two further hits → period 2 and stays 2.
- P1 miss: ball X=1, Y=10, moving left, i_Paddle_Y_P1=20 → X=0, o_P2_Score for one cycle. One tick later the ball is at (20,15); after 2 ticks it moves to X=19.
- Draw: column/row equal to the ball position → o_Draw_Ball high exactly one cycle later; off by one column → 0.
- Spin (macro defined): top-row hit with dir_y down → next Y decreases. Same stimulus without the macro → Y increases.
